uart_tx_framer: RTL and testbench
=================================

// Module: uart_tx_framer
// PURPOSE
// - Synthesizable, parametrised UART transmitter with an input FIFO, runtime baud divider, parity and stop-bit modes.
// - Replaces fixed-rate 8N1 serial stimulus (UDM rx line) with a reusable block.
// - Drives the UDM rx pin, or any 1-wire async serial sink, inside sigma-class SoCs.
// PARAMETERS
// - DATA_W      8   data bits per frame; legal 5..9
// - FIFO_DEPTH  16  word FIFO entries; power of 2, >=2
// - DIV_W       32  width of baud divider; 115200 @100MHz = 868
// PORTS
// - clk_i         in   1                    system clock
// - arst_i        in   1                    async active-high reset
// - cfg_div_i     in   DIV_W                clocks per bit; values <2 treated as 2
// - cfg_parity_i  in   2                    00 none, 01 even, 10 odd, 11 mark (always 1)
// - cfg_stop2_i   in   1                    0: one stop bit, 1: two stop bits
// - wr_req_i      in   1                    push wr_data_i into FIFO
// - wr_data_i     in   DATA_W               word to send, LSB first
// - wr_ack_o      out  1                    =!full; push accepted when wr_req_i & wr_ack_o
// - ovf_clr_i     in   1                    clears overflow_o
// - tx_o          out  1                    serial line, idle high, registered
// - busy_o        out  1                    frame in progress or FIFO non-empty
// - fifo_level_o  out  $clog2(FIFO_DEPTH)+1 FIFO occupancy 0..FIFO_DEPTH
// - overflow_o    out  1                    sticky: push attempted while full
// BEHAVIOUR
// - Reset values: tx_o=1; busy_o=0; fifo_level_o=0; overflow_o=0; wr_ack_o=1; FSM=IDLE; FIFO empty.
// - Reset mid-frame aborts the frame immediately: tx_o=1 asynchronously, FIFO contents discarded.
// - FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
// - IDLE: if FIFO non-empty, pop the word, latch cfg_* into shadow regs, tx_o<=0, go to START.
// - Config is sampled only at the pop. Mid-frame cfg changes do not affect the current frame.
// - Each state holds tx_o for exactly div clocks. Down-counter loads div-1 and advances state at 0.
// - DATA: DATA_W bits, LSB first. Bit index counter runs 0..DATA_W-1.
// - PARITY: entered only if parity!=00. even = ^data; odd = ~^data; mark = 1.
// - STOP: tx_o=1 for div*(1+stop2) clocks.
// - Frame ends at the last STOP clock. If the FIFO is non-empty on that clock, START follows on the very next clock (back-to-back, no idle gap).
// - Latency: word pushed at edge k into empty FIFO with FSM in IDLE -> tx_o falls at edge k+1.
// - Frame length = div*(1+DATA_W+(parity!=0)+1+stop2) clocks.
// - FIFO: synchronous, no write->read bypass. Push and pop in the same clock are both honoured; level unchanged.
// - When full, wr_ack_o=0 and the push is dropped. overflow_o sets to 1 the next edge and holds until ovf_clr_i. Set wins over simultaneous clear.
// - Pointers are $clog2(FIFO_DEPTH) bits and wrap modulo depth. Level is separate, saturating at 0 and DEPTH by construction.
// - busy_o = (FSM!=IDLE) | (level!=0), registered-equivalent. Falls one clock after the last STOP clock.
// STRUCTURE
// - uart_pkg:
//   - parity_e {PAR_NONE, PAR_EVEN, PAR_ODD, PAR_MARK}
//   - tx_state_e {IDLE, START, DATA, PARITY, STOP}
//   - localparam MIN_DIV=2
// - Sub-module uart_sync_fifo #(W, DEPTH): push/pop/full/empty/level. Reused by a future rx framer.
// - Top holds FSM, bit counter, baud down-counter, shift register, cfg shadow regs.
// TESTING
// - div=4, 8N1, push 0xA5 -> tx_o 0,1,0,1,0,0,1,0,1,1 each 4 clocks; 40 clocks total; busy_o low after.
// - div=4, even parity, 2 stop, 0xA5 -> parity bit 0; odd -> 1; mark -> 1; stop high 8 clocks; 48-clock frame.
// - FIFO_DEPTH=4, div=8, push 6 words back-to-back:
//   - wr_ack_o drops after the 5th word (1 popped, 4 held); overflow_o=1 on the 6th.
//   - 5 frames are sent with no idle gap between them.
//   - ovf_clr_i clears overflow_o.
// - cfg_div_i=0 -> behaves as div=2 (20-clock 8N1 frame). Changing cfg_div_i mid-frame leaves the current frame's timing unchanged.
// - Assert arst_i in the middle of DATA of the 2nd of 3 queued words -> tx_o=1, level=0, busy_o=0 immediately.
//   After release, push 0x3C -> one clean frame only.
// - DATA_W=9 build, push 9'h1FF, 8N1-style -> 9 data ones, 1 stop, 11*div clocks.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART framers (tx today, rx later).
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_MARK = 2'b11
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam int MIN_DIV = 2;

    // xor_all is the xor-reduction of the data word.
    function automatic logic parity_bit(parity_e mode, logic xor_all);
        case (mode)
            PAR_EVEN: parity_bit = xor_all;
            PAR_ODD:  parity_bit = ~xor_all;
            PAR_MARK: parity_bit = 1'b1;
            default:  parity_bit = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock word FIFO with occupancy count; push is dropped while full,
// pop is ignored while empty. No write-to-read bypass.
module uart_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       arst_i,
    input  logic                       push_i,
    input  logic [W-1:0]               push_data_i,
    input  logic                       pop_i,
    output logic [W-1:0]               pop_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok, pop_ok;

    assign full_o     = (level_q == LVL_W'(DEPTH));
    assign empty_o    = (level_q == '0);
    assign level_o    = level_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        level_d  = level_q;
        if (push_ok && !pop_ok)
            level_d = level_q + LVL_W'(1);
        else if (!push_ok && pop_ok)
            level_d = level_q - LVL_W'(1);
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the level gates every read.
    always_ff @(posedge clk_i) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmitter: FIFO-fed framer with runtime baud divider, parity and
// 1/2 stop bits. Config is captured per frame at the FIFO pop.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 32
) (
    input  logic                          clk_i,
    input  logic                          arst_i,
    input  logic [DIV_W-1:0]              cfg_div_i,
    input  logic [1:0]                    cfg_parity_i,
    input  logic                          cfg_stop2_i,
    input  logic                          wr_req_i,
    input  logic [DATA_W-1:0]             wr_data_i,
    output logic                          wr_ack_o,
    input  logic                          ovf_clr_i,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          overflow_o
);

    localparam int BIT_W = $clog2(DATA_W);

    logic                        fifo_pop, fifo_full, fifo_empty;
    logic [DATA_W-1:0]           fifo_rdata;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;

    uart_sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i       (clk_i),
        .arst_i      (arst_i),
        .push_i      (wr_req_i),
        .push_data_i (wr_data_i),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_rdata),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level)
    );

    tx_state_e         state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_en_q, par_en_d;
    logic              par_bit_q, par_bit_d;
    logic              stop2_q, stop2_d;
    logic              stop_hi_q, stop_hi_d;
    logic              tx_q, tx_d;
    logic              ovf_q, ovf_d;
    logic [DIV_W-1:0]  div_eff;
    logic              start_frame;

    assign div_eff = (cfg_div_i < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_div_i;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        par_en_d    = par_en_q;
        par_bit_d   = par_bit_q;
        stop2_d     = stop2_q;
        stop_hi_d   = stop_hi_q;
        tx_d        = tx_q;
        fifo_pop    = 1'b0;
        start_frame = 1'b0;

        if (state_q != IDLE && cnt_q != '0) begin
            cnt_d = cnt_q - DIV_W'(1);
        end else begin
            case (state_q)
                IDLE: start_frame = ~fifo_empty;
                START: begin
                    state_d = DATA;
                    cnt_d   = div_q - DIV_W'(1);
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
                DATA: begin
                    cnt_d = div_q - DIV_W'(1);
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d   = STOP;
                            tx_d      = 1'b1;
                            stop_hi_d = 1'b0;
                        end
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
                PARITY: begin
                    state_d   = STOP;
                    cnt_d     = div_q - DIV_W'(1);
                    tx_d      = 1'b1;
                    stop_hi_d = 1'b0;
                end
                STOP: begin
                    if (stop2_q && !stop_hi_q) begin
                        stop_hi_d = 1'b1;
                        cnt_d     = div_q - DIV_W'(1);
                    end else begin
                        // Last stop clock: chain straight into the next frame if queued.
                        state_d     = IDLE;
                        start_frame = ~fifo_empty;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (start_frame) begin
            fifo_pop  = 1'b1;
            state_d   = START;
            div_d     = div_eff;
            cnt_d     = div_eff - DIV_W'(1);
            shift_d   = fifo_rdata;
            par_en_d  = (cfg_parity_i != PAR_NONE);
            par_bit_d = parity_bit(parity_e'(cfg_parity_i), ^fifo_rdata);
            stop2_d   = cfg_stop2_i;
            stop_hi_d = 1'b0;
            tx_d      = 1'b0;
        end
    end

    // Set wins over a simultaneous clear.
    assign ovf_d = (wr_req_i & fifo_full) | (ovf_q & ~ovf_clr_i);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_q     <= DIV_W'(MIN_DIV);
            bit_q     <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            stop_hi_q <= 1'b0;
            tx_q      <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            stop_hi_q <= stop_hi_d;
            tx_q      <= tx_d;
            ovf_q     <= ovf_d;
        end
    end

    assign tx_o         = tx_q;
    assign wr_ack_o     = ~fifo_full;
    assign busy_o       = (state_q != IDLE) | (fifo_level != '0);
    assign fifo_level_o = fifo_level;
    assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench: table of single frames on an 8-bit depth-4 framer, plus
// FIFO/overflow, reset-abort and 9-bit sequences.
module tb_uart_tx_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cfg_div;
    logic [1:0]  cfg_par;
    logic        cfg_stop2;
    logic        wr_req, wr_req9;
    logic [7:0]  wr_data;
    logic [8:0]  wr_data9;
    logic        ovf_clr, ovf_clr9;
    logic        wr_ack, tx, busy, ovf;
    logic [2:0]  level;
    logic        wr_ack9, tx9, busy9, ovf9;
    logic [2:0]  level9;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_framer #(.DATA_W(8), .FIFO_DEPTH(4), .DIV_W(32)) u_dut (
        .clk_i(clk), .arst_i(rst), .cfg_div_i(cfg_div), .cfg_parity_i(cfg_par),
        .cfg_stop2_i(cfg_stop2), .wr_req_i(wr_req), .wr_data_i(wr_data),
        .wr_ack_o(wr_ack), .ovf_clr_i(ovf_clr), .tx_o(tx), .busy_o(busy),
        .fifo_level_o(level), .overflow_o(ovf)
    );

    uart_tx_framer #(.DATA_W(9), .FIFO_DEPTH(4), .DIV_W(32)) u_dut9 (
        .clk_i(clk), .arst_i(rst), .cfg_div_i(cfg_div), .cfg_parity_i(cfg_par),
        .cfg_stop2_i(cfg_stop2), .wr_req_i(wr_req9), .wr_data_i(wr_data9),
        .wr_ack_o(wr_ack9), .ovf_clr_i(ovf_clr9), .tx_o(tx9), .busy_o(busy9),
        .fifo_level_o(level9), .overflow_o(ovf9)
    );

    typedef struct {
        string       name;
        logic [31:0] div;
        logic [1:0]  par;
        logic        stop2;
        logic [7:0]  data;
        int          nbits;
        logic [11:0] bits;   // line bit i = bits[i], each held div clocks
        logic [31:0] mid_div;
        logic [1:0]  mid_par;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic cur_tx(input bit sel);
        return sel ? tx9 : tx;
    endfunction

    function automatic logic cur_busy(input bit sel);
        return sel ? busy9 : busy;
    endfunction

    task automatic run_frame(input bit sel, input logic [8:0] data, input int div_eff,
                             input int nbits, input logic [11:0] bits,
                             input logic [31:0] mid_div, input logic [1:0] mid_par,
                             input string nm);
        int mism;
        @(negedge clk);
        if (sel) begin wr_req9 = 1'b1; wr_data9 = data; end
        else begin wr_req = 1'b1; wr_data = data[7:0]; end
        @(negedge clk);
        wr_req = 1'b0; wr_req9 = 1'b0;
        chk({nm, "_lat_tx"}, 32'(cur_tx(sel)), 32'd1);
        chk({nm, "_lat_busy"}, 32'(cur_busy(sel)), 32'd1);
        for (int b = 0; b < nbits; b++) begin
            mism = 0;
            for (int d = 0; d < div_eff; d++) begin
                @(negedge clk);
                if (b == 2 && d == 0) begin cfg_div = mid_div; cfg_par = mid_par; end
                if (cur_tx(sel) !== bits[b]) mism++;
            end
            chk($sformatf("%s_bit%0d_badclks", nm, b), 32'(mism), 32'd0);
        end
        @(negedge clk);
        chk({nm, "_end_busy"}, 32'(cur_busy(sel)), 32'd0);
        chk({nm, "_end_tx"}, 32'(cur_tx(sel)), 32'd1);
    endtask

    logic [7:0] fw[6];
    int         fmism[5];
    logic [9:0] fr;

    initial begin
        vecs[0] = '{"n8n1_a5",   4, 2'd0, 1'b0, 8'hA5, 10, 12'h34A, 4, 2'd0};
        vecs[1] = '{"even2_a5",  4, 2'd1, 1'b1, 8'hA5, 12, 12'hD4A, 4, 2'd1};
        vecs[2] = '{"odd2_a5",   4, 2'd2, 1'b1, 8'hA5, 12, 12'hF4A, 4, 2'd2};
        vecs[3] = '{"mark1_a5",  4, 2'd3, 1'b0, 8'hA5, 11, 12'h74A, 4, 2'd3};
        vecs[4] = '{"div0_3c",   0, 2'd0, 1'b0, 8'h3C, 10, 12'h278, 0, 2'd0};
        vecs[5] = '{"div1_oddff", 1, 2'd2, 1'b0, 8'hFF, 11, 12'h7FE, 1, 2'd2};
        vecs[6] = '{"div3_ev01", 3, 2'd1, 1'b0, 8'h01, 11, 12'h602, 3, 2'd1};
        vecs[7] = '{"midchg_3c", 4, 2'd0, 1'b0, 8'h3C, 10, 12'h278, 9, 2'd2};

        rst = 1'b1; cfg_div = 32'd4; cfg_par = 2'd0; cfg_stop2 = 1'b0;
        wr_req = 1'b0; wr_data = '0; wr_req9 = 1'b0; wr_data9 = '0;
        ovf_clr = 1'b0; ovf_clr9 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_ack", 32'(wr_ack), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            cfg_div = vecs[i].div; cfg_par = vecs[i].par; cfg_stop2 = vecs[i].stop2;
            run_frame(1'b0, {1'b0, vecs[i].data}, (vecs[i].div < 2) ? 2 : int'(vecs[i].div),
                      vecs[i].nbits, vecs[i].bits, vecs[i].mid_div, vecs[i].mid_par,
                      vecs[i].name);
        end

        // FIFO fill, overflow, back-to-back frames
        cfg_div = 32'd8; cfg_par = 2'd0; cfg_stop2 = 1'b0;
        for (int i = 0; i < 6; i++) fw[i] = 8'h11 + 8'(i * 16 + i);
        for (int i = 0; i < 5; i++) fmism[i] = 0;
        @(negedge clk);
        chk("fifo_ack_w1", 32'(wr_ack), 32'd1);
        wr_req = 1'b1; wr_data = fw[0];
        for (int c = 1; c <= 402; c++) begin
            @(negedge clk);
            if (c < 6) begin
                chk($sformatf("fifo_ack_w%0d", c + 1), 32'(wr_ack), (c < 5) ? 32'd1 : 32'd0);
                wr_data = fw[c];
            end else begin
                wr_req = 1'b0;
            end
            if (c == 6) begin
                chk("fifo_ovf_set", 32'(ovf), 32'd1);
                chk("fifo_level_full", 32'(level), 32'd4);
            end
            if (c >= 2 && c <= 401) begin
                fr = {1'b1, fw[(c - 2) / 80], 1'b0};
                if (tx !== fr[((c - 2) % 80) / 8]) fmism[(c - 2) / 80]++;
            end
            if (c == 402) begin
                chk("fifo_end_busy", 32'(busy), 32'd0);
                chk("fifo_end_tx", 32'(tx), 32'd1);
                chk("fifo_end_level", 32'(level), 32'd0);
            end
        end
        for (int f = 0; f < 5; f++)
            chk($sformatf("fifo_frame%0d_badclks", f), 32'(fmism[f]), 32'd0);
        chk("ovf_sticky", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(ovf), 32'd0);

        // Reset in the middle of the second of three queued frames
        cfg_div = 32'd4;
        @(negedge clk); wr_req = 1'b1; wr_data = 8'h5A;
        @(negedge clk); wr_data = 8'h00;
        @(negedge clk); wr_data = 8'hC3;
        @(negedge clk); wr_req = 1'b0;
        repeat (57) @(negedge clk);
        chk("rstmid_pre_tx", 32'(tx), 32'd0);
        chk("rstmid_pre_level", 32'(level), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rstmid_tx", 32'(tx), 32'd1);
        chk("rstmid_level", 32'(level), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_frame(1'b0, 9'h03C, 4, 10, 12'h278, 4, 2'd0, "post_rst_3c");
        fmism[0] = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) fmism[0]++;
        end
        chk("post_rst_idle_badclks", 32'(fmism[0]), 32'd0);

        // 9-bit build
        cfg_div = 32'd4; cfg_par = 2'd0; cfg_stop2 = 1'b0;
        run_frame(1'b1, 9'h1FF, 4, 11, 12'h7FE, 4, 2'd0, "w9_1ff");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
